// File: rtl/oled_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_pkg
// Description : Shared types and constants for the OLED SPI write scheduler:
//               frame state encoding, default timing parameters, DnC encoding
//               and a small helper for sizing counters.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CMD_RUN  = 4;

    localparam logic DNC_CMD  = 1'b0;
    localparam logic DNC_DATA = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_timer
// Description : Loadable down-counter. Loading N makes done rise in the N-th
//               cycle after the load edge (the last cycle of the interval), so
//               the controller can reload on done with no dead cycle.
// Ports       : clk, rst (async, active-high), load, load_value (>=1), done
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value - W'(1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/oled_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_scheduler
// Description : Shares the OLED serial write port between a command requester
//               and a pixel-data requester. Arbitrates with a bounded command
//               run, frames each byte with nCS, drives DnC and shifts the byte
//               out MSB-first in SPI mode 0.
// Ports       : Clock, Reset (async, active-high)
//               CmdValid/CmdByte/CmdReady - command byte handshake
//               DatValid/DatByte/DatReady - data byte handshake
//               Busy                      - frame in progress
//               SpiClk, SDIN, DnC, nCS    - display pad signals
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_scheduler
    import oled_spi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CMD_RUN  = DEF_CMD_RUN
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic [7:0] CmdByte,
    output logic       CmdReady,
    input  logic       DatValid,
    input  logic [7:0] DatByte,
    output logic       DatReady,
    output logic       Busy,
    output logic       SpiClk,
    output logic       SDIN,
    output logic       DnC,
    output logic       nCS
);

    localparam int PH_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
    localparam int SV_W = $clog2(CMD_RUN + 1);

    state_t          state, next_state;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic            phase;      // 0 = SpiClk low half, 1 = high half
    logic            dnc;
    logic [SV_W-1:0] starve_cnt;

    logic            idle;
    logic            starve;
    logic            cmd_take;
    logic            dat_take;
    logic            timer_load;
    logic [PH_W-1:0] timer_value;
    logic            timer_done;

    // Grant: commands win unless they have held the port CMD_RUN times in a
    // row while data was waiting.
    assign idle     = (state == IDLE);
    assign starve   = (starve_cnt == SV_W'(CMD_RUN)) && DatValid;
    assign CmdReady = idle && CmdValid && !starve;
    assign DatReady = idle && DatValid && (starve || !CmdValid);
    assign cmd_take = CmdValid && CmdReady;
    assign dat_take = DatValid && DatReady;

    spi_bit_timer #(
        .W (PH_W)
    ) u_timer (
        .clk        (Clock),
        .rst        (Reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = PH_W'(CLK_DIV);
        case (state)
            IDLE: begin
                if (cmd_take || dat_take) begin
                    next_state  = SETUP;
                    timer_load  = 1'b1;
                    timer_value = PH_W'(CS_SETUP);
                end
            end
            SETUP: begin
                if (timer_done) begin
                    next_state = SHIFT;
                    timer_load = 1'b1;
                end
            end
            SHIFT: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (phase && (bit_idx == 3'd7)) begin
                        next_state  = HOLD;
                        timer_value = PH_W'(CS_HOLD);
                    end
                end
            end
            HOLD: begin
                if (timer_done) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: byte capture, bit sequencing and starvation tracking.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shreg      <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            dnc        <= DNC_CMD;
            starve_cnt <= '0;
        end else begin
            if (dat_take) begin
                shreg <= DatByte;
                dnc   <= DNC_DATA;
            end else if (cmd_take) begin
                shreg <= CmdByte;
                dnc   <= DNC_CMD;
            end

            if (state == SETUP && timer_done) begin
                phase   <= 1'b0;
                bit_idx <= '0;
            end

            // Next bit is presented at the start of each low half, so SDIN
            // is stable across the following rising edge.
            if (state == SHIFT && timer_done) begin
                if (!phase) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (bit_idx != 3'd7) begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                end
            end

            if (dat_take) begin
                starve_cnt <= '0;
            end else if (cmd_take) begin
                if (!DatValid) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != SV_W'(CMD_RUN)) begin
                    starve_cnt <= starve_cnt + SV_W'(1);
                end
            end
        end
    end

    assign Busy   = !idle;
    assign nCS    = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
    assign SpiClk = (state == SHIFT) && phase;
    assign SDIN   = shreg[7];
    assign DnC    = dnc;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_spi_scheduler
// Description : Directed self-checking bench. Instance a uses default timing,
//               instance b uses the minimum timing (1/1/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_spi_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       rst_a, a_cmd_valid, a_dat_valid;
    logic [7:0] a_cmd_byte, a_dat_byte;
    logic       a_cmd_ready, a_dat_ready, a_busy, a_spiclk, a_sdin, a_dnc, a_ncs;
    logic       rst_b, b_cmd_valid, b_dat_valid;
    logic [7:0] b_cmd_byte, b_dat_byte;
    logic       b_cmd_ready, b_dat_ready, b_busy, b_spiclk, b_sdin, b_dnc, b_ncs;

    oled_spi_scheduler dut_a (
        .Clock(clk), .Reset(rst_a),
        .CmdValid(a_cmd_valid), .CmdByte(a_cmd_byte), .CmdReady(a_cmd_ready),
        .DatValid(a_dat_valid), .DatByte(a_dat_byte), .DatReady(a_dat_ready),
        .Busy(a_busy), .SpiClk(a_spiclk), .SDIN(a_sdin), .DnC(a_dnc), .nCS(a_ncs)
    );

    oled_spi_scheduler #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CMD_RUN(4)) dut_b (
        .Clock(clk), .Reset(rst_b),
        .CmdValid(b_cmd_valid), .CmdByte(b_cmd_byte), .CmdReady(b_cmd_ready),
        .DatValid(b_dat_valid), .DatByte(b_dat_byte), .DatReady(b_dat_ready),
        .Busy(b_busy), .SpiClk(b_spiclk), .SDIN(b_sdin), .DnC(b_dnc), .nCS(b_ncs)
    );

    // Selected-instance view so one set of tasks serves both instances.
    logic sel = 1'b0;
    logic m_cmd_ready, m_dat_ready, m_busy, m_spiclk, m_sdin, m_dnc, m_ncs;
    assign m_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
    assign m_dat_ready = sel ? b_dat_ready : a_dat_ready;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_spiclk    = sel ? b_spiclk    : a_spiclk;
    assign m_sdin      = sel ? b_sdin      : a_sdin;
    assign m_dnc       = sel ? b_dnc       : a_dnc;
    assign m_ncs       = sel ? b_ncs       : a_ncs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte right after a falling edge and confirm the grant.
    task automatic start(input logic is_data, input logic [7:0] b);
        if (!sel) begin
            if (is_data) begin a_dat_valid = 1'b1; a_dat_byte = b; end
            else         begin a_cmd_valid = 1'b1; a_cmd_byte = b; end
        end else begin
            if (is_data) begin b_dat_valid = 1'b1; b_dat_byte = b; end
            else         begin b_cmd_valid = 1'b1; b_cmd_byte = b; end
        end
        #1;
        chk(is_data ? "dat_ready" : "cmd_ready", is_data ? m_dat_ready : m_cmd_ready, 1);
        chk("other_ready_low", is_data ? m_cmd_ready : m_dat_ready, 0);
    endtask

    // Let the accept edge pass, then observe the frame once per cycle until
    // Busy drops. Optionally pulses DatValid on instance a at cycle pulse_at.
    task automatic capture(input logic exp_dnc, input int pulse_at,
                           output logic [7:0] bits, output int busy_n,
                           output int ncs_n, output int rises, output int first_rise);
        int   first_low;
        logic prev;
        logic dnc_bad;
        logic ended;
        bits = 8'h00; busy_n = 0; ncs_n = 0; rises = 0; first_rise = -1;
        first_low = -1; prev = 1'b0; dnc_bad = 1'b0; ended = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_cmd_valid = 1'b0; a_dat_valid = 1'b0;
        b_cmd_valid = 1'b0; b_dat_valid = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) @(negedge clk);
            if (i == pulse_at)     begin a_dat_valid = 1'b1; a_dat_byte = 8'hE7; end
            if (i == pulse_at + 1) a_dat_valid = 1'b0;
            #1;
            if (i == pulse_at) chk("dat_ready_while_busy", m_dat_ready, 0);
            if (!m_busy) begin
                ended = 1'b1;
                break;
            end
            busy_n++;
            if (!m_ncs) begin
                ncs_n++;
                if (first_low < 0) first_low = i;
            end
            if (m_dnc !== exp_dnc) dnc_bad = 1'b1;
            if (m_spiclk && !prev) begin
                if (first_rise < 0) first_rise = i - first_low;
                bits = {bits[6:0], m_sdin};
                rises++;
            end
            prev = m_spiclk;
        end
        chk("frame_ends", ended, 1);
        chk("dnc_held_in_frame", dnc_bad, 0);
        chk("dnc_after_frame", m_dnc, exp_dnc);
        chk("ncs_high_after_frame", m_ncs, 1);
    endtask

    logic [7:0] bits;
    int busy_n, ncs_n, rises, first_rise;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_cmd_valid = 0; a_dat_valid = 0; a_cmd_byte = 0; a_dat_byte = 0;
        b_cmd_valid = 0; b_dat_valid = 0; b_cmd_byte = 0; b_dat_byte = 0;

        // Reset state
        #1;
        chk("rst_ncs", a_ncs, 1);
        chk("rst_spiclk", a_spiclk, 0);
        chk("rst_sdin", a_sdin, 0);
        chk("rst_dnc", a_dnc, 0);
        chk("rst_busy", a_busy, 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Single command 0xAF, default timing
        @(negedge clk);
        start(1'b0, 8'hAF);
        capture(1'b0, -10, bits, busy_n, ncs_n, rises, first_rise);
        chk("af_bits", bits, 8'hAF);
        chk("af_rises", rises, 8);
        chk("af_ncs_low", ncs_n, 68);
        chk("af_busy", busy_n, 69);
        chk("af_first_rise", first_rise, 6);

        // Single data 0x3C
        @(negedge clk);
        start(1'b1, 8'h3C);
        capture(1'b1, -10, bits, busy_n, ncs_n, rises, first_rise);
        chk("3c_bits", bits, 8'h3C);
        chk("3c_busy", busy_n, 69);

        // DatValid pulsed mid-frame must not produce a frame
        @(negedge clk);
        start(1'b0, 8'h81);
        capture(1'b0, 10, bits, busy_n, ncs_n, rises, first_rise);
        chk("81_bits", bits, 8'h81);
        begin
            logic busy_seen;
            busy_seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk); #1;
                if (a_busy || a_dat_ready) busy_seen = 1'b1;
            end
            chk("no_frame_for_pulse", busy_seen, 0);
        end

        // Arbitration with both requesters held high
        @(negedge clk);
        a_cmd_valid = 1'b1; a_cmd_byte = 8'h11;
        a_dat_valid = 1'b1; a_dat_byte = 8'h22;
        begin
            int grants, last;
            logic [9:0] order;
            logic bad_period, both_ready;
            grants = 0; last = -1; order = '0; bad_period = 0; both_ready = 0;
            for (int cyc = 0; cyc < 1000 && grants < 10; cyc++) begin
                if (cyc > 0) @(negedge clk);
                #1;
                if (a_cmd_ready && a_dat_ready) both_ready = 1'b1;
                if (a_cmd_ready || a_dat_ready) begin
                    order[grants] = a_dat_ready;
                    if (last >= 0 && (cyc - last) != 70) bad_period = 1'b1;
                    last = cyc;
                    grants++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            a_cmd_valid = 1'b0; a_dat_valid = 1'b0;
            chk("arb_grants", grants, 10);
            chk("arb_order", order, 10'b10000_10000);
            chk("arb_period", bad_period, 0);
            chk("arb_one_ready", both_ready, 0);
            for (int i = 0; i < 100 && a_busy; i++) @(negedge clk);
            #1;
            chk("arb_drained", a_busy, 0);
        end

        // Reset 20 cycles into a frame
        @(negedge clk);
        start(1'b0, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        a_cmd_valid = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        chk("mid_busy", a_busy, 1);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_ncs", a_ncs, 1);
        chk("mid_rst_spiclk", a_spiclk, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_sdin", a_sdin, 0);
        @(negedge clk);
        rst_a = 1'b0;
        start(1'b0, 8'h5A);
        capture(1'b0, -10, bits, busy_n, ncs_n, rises, first_rise);
        chk("5a_bits", bits, 8'h5A);
        chk("5a_busy", busy_n, 69);

        // Minimum timing instance
        sel = 1'b1;
        @(negedge clk);
        start(1'b0, 8'hA5);
        capture(1'b0, -10, bits, busy_n, ncs_n, rises, first_rise);
        chk("fast_bits", bits, 8'hA5);
        chk("fast_rises", rises, 8);
        chk("fast_busy", busy_n, 19);
        chk("fast_ncs_low", ncs_n, 18);
        chk("fast_first_rise", first_rise, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oled_spi_scheduler.md
# oled_spi_scheduler

Shares the OLED display's serial write port between two byte requesters: the command path (init/config) and the pixel-data path. Arbitrates between them, frames each byte with nCS, drives DnC, generates the SPI clock and shifts the byte out MSB-first. Sits in the computer core between the display-control logic and the core-side OLED pad signals.

## Interface
- CLK_DIV, 4: SpiClk half-period in Clock cycles; must be ≥1.
- CS_SETUP, 2: cycles from nCS low to first SpiClk rise window; must be ≥1.
- CS_HOLD, 2: cycles from last SpiClk fall to nCS high; must be ≥1.
- CMD_RUN, 4: max consecutive command grants while data is waiting; must be ≥1.
- Clock  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command byte offered.
- CmdByte  in  8  command byte.
- CmdReady  out  1  command byte accepted this cycle when CmdValid=1.
- DatValid  in  1  data byte offered.
- DatByte  in  8  data byte.
- DatReady  out  1  data byte accepted this cycle when DatValid=1.
- Busy  out  1  transfer in progress (state ≠ IDLE).
- SpiClk  out  1  serial clock, idle low (mode 0).
- SDIN  out  1  serial data, MSB first.
- DnC  out  1  0 = command, 1 = data; held for the whole frame.
- nCS  out  1  active-low chip select.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: nCS=1, SpiClk=0. Readys are combinational, asserted only in IDLE, and only for the granted requester. Handshake completes when Valid && Ready at a rising edge.
- Grant: CmdReady=CmdValid unless the starvation counter equals CMD_RUN and DatValid=1; in that case DatReady=1 and CmdReady=0. Otherwise DatReady=DatValid && !CmdValid.
- Starvation counter: increments on each command grant while DatValid=1. Clears on any data grant, and whenever DatValid=0 at a command grant. Saturates at CMD_RUN.
- On accept: latch byte into shift register; DnC=0 for cmd or 1 for data; enter SETUP.
- SETUP: nCS=0, SpiClk=0, SDIN=bit7, lasts CS_SETUP cycles.
- SHIFT: 8 bits, each CLK_DIV cycles SpiClk=0 then CLK_DIV cycles SpiClk=1. SDIN updates to the next bit at the start of each low phase and is stable across the rising edge.
- HOLD: SpiClk=0, nCS=0, CS_HOLD cycles.
- GAP: nCS=1, 1 cycle (minimum deselect time).
- DnC is unchanged from accept until the next accept.
- Valid may drop without a handshake; no byte is taken unless Ready was high.

## Timing
- Reset values, applied immediately and asynchronously: state=IDLE, nCS=1, SpiClk=0, SDIN=0, DnC=0, Busy=0, starvation counter=0, shift register=0.
- Accept at edge 0 → nCS falls after edge 0. Frame lasts CS_SETUP + 16·CLK_DIV + CS_HOLD + 1 cycles (defaults: 69). Next Ready goes high in the cycle after GAP.
- First SpiClk rise: CS_SETUP + CLK_DIV cycles after nCS falls (defaults: 6).
- Reset mid-frame: byte is discarded, outputs go to reset values, no partial retransmit.
- Simultaneous Valids: the grant rule above decides; exactly one Ready is high at a time.
- Counter widths: $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD)+1) bits for phase timing; 3-bit bit index; no wrap beyond 7.

## Structure
- Package oled_spi_pkg holds: the state enum (IDLE, SETUP, SHIFT, HOLD, GAP), default parameter constants, and the DnC encoding localparams (DNC_CMD=0, DNC_DATA=1).
- Sub-module spi_bit_timer: loadable down-counter with a done strobe. It is reused for the SETUP, the SHIFT half-periods and the HOLD durations.

## Test plan
- Single command 0xAF, defaults → nCS low for 68 cycles; DnC=0; SDIN sampled on 8 SpiClk rises = 1,0,1,0,1,1,1,1; Busy high 69 cycles.
- Single data 0x3C → DnC=1; sampled bits 0,0,1,1,1,1,0,0; DnC stays 1 after nCS rises.
- CmdValid and DatValid both held high continuously, CMD_RUN=4 → grant order C,C,C,C,D,C,C,C,C,D; frames separated by exactly one GAP cycle with nCS=1.
- Reset pulsed 20 cycles into a frame → nCS=1, SpiClk=0, Busy=0 the same cycle; next request is accepted in the first IDLE cycle after reset releases.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 → frame of 19 cycles, SpiClk toggles every cycle, no lost bit.
- DatValid pulsed for 1 cycle while Busy → DatReady never high; no frame is sent for that byte.
